// File: rtl/regfile_mp.sv
// regfile_mp: multi-port integer register file with hardwired-zero x0,
// optional same-cycle write-to-read bypass and a per-register busy
// scoreboard (issue claims a destination, writeback clears it).
module regfile_mp #(
   parameter int XLEN   = 32,
   parameter int NREG   = 32,
   parameter int NRD    = 2,
   parameter int NWR    = 1,
   parameter int BYPASS = 1,
   localparam int AW    = $clog2(NREG)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NWR-1:0]       wend,
   input  logic [NWR*AW-1:0]    write_adr,
   input  logic [NWR*XLEN-1:0]  write_data,
   input  logic [NRD*AW-1:0]    read_adr,
   output logic [NRD*XLEN-1:0]  read_data,
   output logic [NRD-1:0]       read_busy,
   input  logic                 claim_en,
   input  logic [AW-1:0]        claim_adr,
   output logic [NREG-1:0]      busy_vec
);

   // x0 has no storage; entries 1..NREG-1 only
   logic [XLEN-1:0] mem_q [1:NREG-1];
   logic [XLEN-1:0] mem_d [1:NREG-1];
   logic [NREG-1:1] busy_q;
   logic [NREG-1:1] busy_d;

   // Next state per register: later write ports override earlier ones,
   // a write clears busy, and a same-cycle claim re-sets it (new producer wins)
   always_comb begin
      for (int r = 1; r < NREG; r++) begin
         mem_d[r]  = mem_q[r];
         busy_d[r] = busy_q[r];
         for (int k = 0; k < NWR; k++) begin
            if (wend[k] && (write_adr[k*AW +: AW] == AW'(r))) begin
               mem_d[r]  = write_data[k*XLEN +: XLEN];
               busy_d[r] = 1'b0;
            end
         end
         if (claim_en && (claim_adr == AW'(r)))
            busy_d[r] = 1'b1;
      end
   end

   // Storage and scoreboard; reset clears everything asynchronously
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 1; r < NREG; r++)
            mem_q[r] <= '0;
         busy_q <= '0;
      end else begin
         mem_q  <= mem_d;
         busy_q <= busy_d;
      end
   end

   assign busy_vec = {busy_q, 1'b0};

   // Read ports: x0 and reset force zero; a bypassed write both supplies
   // the data and hides the busy flag since the value is arriving now
   always_comb begin
      read_data = '0;
      read_busy = '0;
      for (int i = 0; i < NRD; i++) begin
         if (!rst && (read_adr[i*AW +: AW] != '0)) begin
            read_data[i*XLEN +: XLEN] = mem_q[read_adr[i*AW +: AW]];
            read_busy[i]              = busy_q[read_adr[i*AW +: AW]];
            if (BYPASS != 0) begin
               for (int k = 0; k < NWR; k++) begin
                  if (wend[k] && (write_adr[k*AW +: AW] == read_adr[i*AW +: AW])) begin
                     read_data[i*XLEN +: XLEN] = write_data[k*XLEN +: XLEN];
                     read_busy[i]              = 1'b0;
                  end
               end
            end
         end
      end
   end

endmodule
